// File: rtl/stack_level_ctrl.sv
// stack_level_ctrl
//   Row sequencer for the stacker game. It enables the shifter of the live
//   row and waits for a stop press. After a settle delay it samples the frozen
//   block and either latches it into the stack or ends the game. It also
//   drives the reference pattern and speed of the live row, and scans the
//   stack onto the 8x8 LED matrix.
//
//   Optional build macro: STACK_BLINK_EN
//     Blinks the matrix in LOSE/WIN with a half-period of BLINK_DIV cycles.
//
// Ports
//   clk        in   system clock
//   resetN     in   asynchronous active-low reset
//   startSw    in   game enable; 0 aborts and clears the game
//   stopBtn    in   raw stop button, active-low, asynchronous
//   rowBlock   in   live row's block pattern from the shifter
//   rowNext    in   live row's accept flag from the shifter
//   rowEn      out  one-hot enable for the live row's shifter
//   levelPrev  out  reference pattern for the live row (stack of row below)
//   speedSel   out  shifter tick-rate select (row index, saturates at 7)
//   gameOver   out  high while in LOSE
//   gameWin    out  high while in WIN
//   ledRow     out  one-hot matrix row strobe
//   ledCol     out  column data for the strobed row
//
// state  | meaning
// IDLE   | game off, everything cleared
// ARM    | waiting for the stop button to be released before enabling the row
// PLAY   | live row shifting, waiting for a stop press
// SETTLE | counting down so the shifter can freeze before sampling
// CHECK  | judging the sampled block
// LOSE   | game over, hold until startSw drops
// WIN    | stack complete, hold until startSw drops

module stack_level_ctrl #(
  parameter int unsigned NUM_ROWS   = 8,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned SCAN_DIV   = 1024,
  parameter int unsigned BLINK_DIV  = 2**22
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startSw,
  input  logic                stopBtn,
  input  logic [7:0]          rowBlock,
  input  logic                rowNext,
  output logic [NUM_ROWS-1:0] rowEn,
  output logic [7:0]          levelPrev,
  output logic [2:0]          speedSel,
  output logic                gameOver,
  output logic                gameWin,
  output logic [7:0]          ledRow,
  output logic [7:0]          ledCol
);

  localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC);
  localparam logic [SCAN_W-1:0]   SCAN_LOAD   = SCAN_W'(SCAN_DIV - 1);
  localparam logic [NUM_ROWS-1:0] ROW_ONE     = NUM_ROWS'(1);

  generate
    if (NUM_ROWS < 1 || NUM_ROWS > 8 || SETTLE_CYC < 1 || BLINK_DIV < 1) begin : g_bad_param
      $error("stack_level_ctrl: parameter out of range");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, ARM, PLAY, SETTLE, CHECK, LOSE, WIN} state_t;

  state_t              state;
  logic [2:0]          row;
  logic [7:0]          stack [NUM_ROWS];
  logic [SETTLE_W-1:0] settleCnt;
  logic [7:0]          sampBlock;
  logic                sampNext;

  // Button idles high, so the synchroniser resets released to avoid a false press.
  logic stopMeta, stopSync, stopLast, press;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stopMeta <= 1'b1;
      stopSync <= 1'b1;
      stopLast <= 1'b1;
    end else begin
      stopMeta <= stopBtn;
      stopSync <= stopMeta;
      stopLast <= stopSync;
    end
  end

  assign press = stopLast & ~stopSync;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      row       <= '0;
      rowEn     <= '0;
      speedSel  <= '0;
      gameOver  <= 1'b0;
      gameWin   <= 1'b0;
      settleCnt <= '0;
      sampBlock <= '0;
      sampNext  <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) stack[i] <= '0;
    end else if (!startSw) begin
      state     <= IDLE;
      row       <= '0;
      rowEn     <= '0;
      speedSel  <= '0;
      gameOver  <= 1'b0;
      gameWin   <= 1'b0;
      settleCnt <= '0;
      for (int i = 0; i < NUM_ROWS; i++) stack[i] <= '0;
    end else begin
      case (state)
        IDLE: state <= ARM;
        ARM: begin
          if (stopSync) begin
            rowEn <= ROW_ONE << row;
            state <= PLAY;
          end
        end
        PLAY: begin
          if (press) begin
            settleCnt <= SETTLE_LOAD;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (settleCnt == '0) begin
            sampBlock <= rowBlock;
            sampNext  <= rowNext;
            state     <= CHECK;
          end else begin
            settleCnt <= settleCnt - 1'b1;
          end
        end
        CHECK: begin
          rowEn <= '0;
          if (!sampNext || sampBlock == 8'h00) begin
            gameOver <= 1'b1;
            state    <= LOSE;
          end else begin
            stack[row] <= sampBlock;
            if (32'(row) == NUM_ROWS - 1) begin
              gameWin <= 1'b1;
              state   <= WIN;
            end else begin
              row      <= row + 3'd1;
              speedSel <= (row == 3'd7) ? 3'd7 : row + 3'd1;
              state    <= ARM;
            end
          end
        end
        LOSE, WIN: rowEn <= '0;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    levelPrev = '0;
    if (row != 3'd0) levelPrev = stack[row - 3'd1];
  end

  logic [SCAN_W-1:0] scanCnt;
  logic [2:0]        scanIdx;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      scanCnt <= SCAN_LOAD;
      scanIdx <= '0;
    end else if (scanCnt == '0) begin
      scanCnt <= SCAN_LOAD;
      scanIdx <= scanIdx + 3'd1;
    end else begin
      scanCnt <= scanCnt - 1'b1;
    end
  end

  assign ledRow = 8'h01 << scanIdx;

  logic [7:0] colData;

  // The live row shows the moving block; all other rows show the stack.
  always_comb begin
    colData = '0;
    if (scanIdx == row && (state == PLAY || state == SETTLE)) colData = rowBlock;
    else if (32'(scanIdx) < NUM_ROWS) colData = stack[scanIdx];
  end

`ifdef STACK_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blinkCnt;
  logic               blinkPhase;
  logic               endState;

  assign endState = (state == LOSE) || (state == WIN);

  // Held at reload while playing so the blink always starts visible on entry.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blinkCnt   <= BLINK_LOAD;
      blinkPhase <= 1'b0;
    end else if (!endState) begin
      blinkCnt   <= BLINK_LOAD;
      blinkPhase <= 1'b0;
    end else if (blinkCnt == '0) begin
      blinkCnt   <= BLINK_LOAD;
      blinkPhase <= ~blinkPhase;
    end else begin
      blinkCnt <= blinkCnt - 1'b1;
    end
  end

  assign ledCol = (endState && blinkPhase) ? 8'h00 : colData;
`else
  assign ledCol = colData;
`endif

endmodule

// File: tb/tb_stack_level_ctrl.sv
module tb_stack_level_ctrl;
  localparam int SETTLE = 4;
  localparam int SCAN   = 4;
  localparam int BLINK  = 8;

  logic       clk = 1'b0;
  logic       resetN, startSw, stopBtn, rowNext;
  logic [7:0] rowBlock;
  logic [7:0] rowEn, levelPrev, ledRow, ledCol;
  logic [2:0] speedSel;
  logic       gameOver, gameWin;

  stack_level_ctrl #(
    .NUM_ROWS(8), .SETTLE_CYC(SETTLE), .SCAN_DIV(SCAN), .BLINK_DIV(BLINK)
  ) dut (
    .clk(clk), .resetN(resetN), .startSw(startSw), .stopBtn(stopBtn),
    .rowBlock(rowBlock), .rowNext(rowNext), .rowEn(rowEn), .levelPrev(levelPrev),
    .speedSel(speedSel), .gameOver(gameOver), .gameWin(gameWin),
    .ledRow(ledRow), .ledCol(ledCol)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_rowEn(input logic [7:0] t, input int lim);
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (rowEn == t) break;
    end
    chk("wait_rowEn", rowEn, t);
  endtask

  task automatic wait_ledRow(input logic [7:0] t, input int lim);
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (ledRow == t) break;
    end
    chk("wait_ledRow", ledRow, t);
  endtask

  typedef struct {
    logic       start;
    logic       stop;
    logic [7:0] blk;
    logic       nxt;
    int         cyc;
    logic [7:0] eRowEn;
    logic [7:0] eLevel;
    logic [2:0] eSpeed;
    logic       eOver;
    logic       eWin;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] expCol;
    logic [7:0] seen;

    vecs[0] = '{1'b0, 1'b1, 8'h00, 1'b0,  2, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h00, 1'b0,  3, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h18, 1'b1, 12, 8'h00, 8'h18, 3'd1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h18, 1'b1,  4, 8'h02, 8'h18, 3'd1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 12, 8'h00, 8'h18, 3'd1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 8'h00, 1'b0,  3, 8'h00, 8'h18, 3'd1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b0,  1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 8'h00, 1'b0,  3, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 8'h3C, 1'b0, 12, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 8'h00, 1'b0,  2, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

    resetN = 1'b0; startSw = 1'b0; stopBtn = 1'b1; rowBlock = '0; rowNext = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rowEn", rowEn, 8'h00);
    chk("rst_levelPrev", levelPrev, 8'h00);
    chk("rst_speedSel", 8'(speedSel), 8'h00);
    chk("rst_gameOver", 8'(gameOver), 8'h00);
    chk("rst_gameWin", 8'(gameWin), 8'h00);
    chk("rst_ledRow", ledRow, 8'h01);
    chk("rst_ledCol", ledCol, 8'h00);
    resetN = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      startSw = vecs[i].start; stopBtn = vecs[i].stop;
      rowBlock = vecs[i].blk;  rowNext = vecs[i].nxt;
      repeat (vecs[i].cyc) @(negedge clk);
      chk($sformatf("v%0d_rowEn", i), rowEn, vecs[i].eRowEn);
      chk($sformatf("v%0d_levelPrev", i), levelPrev, vecs[i].eLevel);
      chk($sformatf("v%0d_speedSel", i), 8'(speedSel), 8'(vecs[i].eSpeed));
      chk($sformatf("v%0d_gameOver", i), 8'(gameOver), 8'(vecs[i].eOver));
      chk($sformatf("v%0d_gameWin", i), 8'(gameWin), 8'(vecs[i].eWin));
    end

    // Live row display, exact sample cycle, re-press in SETTLE ignored, held button in ARM.
    startSw = 1'b1; stopBtn = 1'b1; rowBlock = 8'h5A; rowNext = 1'b1;
    wait_rowEn(8'h01, 10);
    wait_ledRow(8'h01, 40);
    chk("live_row_col", ledCol, 8'h5A);
    rowBlock = 8'h00;
    stopBtn = 1'b0;
    repeat (2) @(negedge clk);
    stopBtn = 1'b1;
    repeat (2) @(negedge clk);
    stopBtn = 1'b0;
    repeat (3) @(negedge clk);
    rowBlock = 8'h10;
    @(negedge clk);
    rowBlock = 8'h00;
    repeat (6) @(negedge clk);
    chk("held_arm_rowEn", rowEn, 8'h00);
    chk("exact_sample_gameOver", 8'(gameOver), 8'h00);
    chk("exact_sample_speedSel", 8'(speedSel), 8'h01);
    chk("exact_sample_levelPrev", levelPrev, 8'h10);
    rowBlock = 8'hC3;
    stopBtn = 1'b1;
    wait_rowEn(8'h02, 10);
    wait_ledRow(8'h01, 40);
    chk("stack_row0_col", ledCol, 8'h10);
    wait_ledRow(8'h02, 40);
    chk("live_row1_col", ledCol, 8'hC3);

    // Abort mid-game.
    startSw = 1'b0;
    @(negedge clk);
    chk("abort_rowEn", rowEn, 8'h00);
    chk("abort_levelPrev", levelPrev, 8'h00);
    chk("abort_speedSel", 8'(speedSel), 8'h00);
    wait_ledRow(8'h01, 40);
    chk("abort_stack_col", ledCol, 8'h00);

    // Full game of eight rows of 8'h10.
    startSw = 1'b1; stopBtn = 1'b1; rowBlock = 8'h10; rowNext = 1'b1;
    for (int r = 0; r < 8; r++) begin
      wait_rowEn(8'(1 << r), 30);
      chk($sformatf("win_r%0d_speedSel", r), 8'(speedSel), 8'(r));
      chk($sformatf("win_r%0d_levelPrev", r), levelPrev, (r == 0) ? 8'h00 : 8'h10);
      stopBtn = 1'b0;
      repeat (2) @(negedge clk);
      stopBtn = 1'b1;
    end
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (gameWin) break;
    end
    chk("win_flag", 8'(gameWin), 8'h01);
    chk("win_speedSel", 8'(speedSel), 8'h07);
    chk("win_rowEn", rowEn, 8'h00);
    chk("win_gameOver", 8'(gameOver), 8'h00);

    seen = '0;
    for (int k = 0; k < 64; k++) begin
`ifdef STACK_BLINK_EN
      expCol = (((k / BLINK) % 2) == 0) ? 8'h10 : 8'h00;
`else
      expCol = 8'h10;
`endif
      chk($sformatf("win_scan_col_k%0d", k), ledCol, expCol);
      chk($sformatf("win_scan_onehot_k%0d", k), 8'($onehot(ledRow)), 8'h01);
      seen = seen | ledRow;
      @(negedge clk);
    end
    chk("win_scan_rows_seen", seen, 8'hFF);

    startSw = 1'b0;
    @(negedge clk);
    chk("end_gameWin", 8'(gameWin), 8'h00);
    chk("end_speedSel", 8'(speedSel), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
